triangle_scan_gen: RTL and testbench
====================================

// Module: triangle_scan_gen
// PURPOSE
//  Upstream feeder for the barycentric stage. Accepts one triangle (three integer pixel-space vertices),
//  computes its screen-clamped bounding box, and walks it in raster order. Emits one candidate pixel per
//  transfer: FP16 p_x/p_y for the float datapath, integer pix_x/pix_y for framebuffer addressing.
//  Vertices are held stable on outputs during the whole scan.
// PARAMETERS
//  SCREEN_W  640  horizontal resolution; max legal x = SCREEN_W-1 (must be <= 2048)
//  SCREEN_H  480  vertical resolution; max legal y = SCREEN_H-1 (must be <= 2048)
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous, active-high reset
//  tri_nd      in   1   new triangle valid
//  tri_rfd     out  1   ready for triangle; 1 only in IDLE
//  v1_x..v3_y  in   16  six vertex coords, unsigned integer pixels
//  ds_rfd      in   1   downstream ready (barycentric us_rfd)
//  nd          out  1   pixel valid to downstream
//  p_x, p_y    out  16  pixel coords, IEEE FP16
//  pix_x,pix_y out  16  same pixel, unsigned integer
//  last        out  1   current pixel is final pixel of triangle
//  o_v1_x..o_v3_y out 16  registered vertices, FP16, stable from accept until return to IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, tri_rfd=1, nd=0, last=0, all data outputs 0. Reset mid-scan aborts immediately;
//    no further nd; the in-flight triangle is discarded.
//  - Triangle accept: tri_nd & tri_rfd on cycle T. Vertices captured; IDLE->SETUP; tri_rfd=0 from T+1.
//  - SETUP (1 cycle): min/max of x and y over 3 vertices; max clamped to SCREEN_W-1 / SCREEN_H-1.
//    If min_x > SCREEN_W-1 or min_y > SCREEN_H-1: empty -> IDLE (tri_rfd=1 at T+2), nd never asserted.
//    Otherwise x=min_x, y=min_y -> SCAN; first nd=1 at T+2.
//  - SCAN: transfer = nd & ds_rfd. No transfer: nd, p_*, pix_*, last held unchanged.
//    Transfer: x<max_x -> x+1; else x=min_x, y+1. Transfer with last=1 -> IDLE next cycle (nd=0, tri_rfd=1).
//    Throughput: one pixel/cycle while ds_rfd=1.
//  - last = (x==max_x) & (y==max_y), registered with pixel data.
//  - Degenerate triangle (coincident/collinear vertices) is not rejected; its bbox is scanned normally.
//    Single-pixel bbox gives one pixel with last=1.
//  - tri_nd outside IDLE is ignored (no capture).
//  - Integer->FP16 conversion is exact for 0..2047:
//    0 -> 0x0000; else exp = 15 + msb index, mantissa = bits below msb left-aligned to 10 bits.
//    p_*/pix_* registered on the same edge, so FP16 and integer always describe the same pixel.
//  - Counters are 16-bit; clamp guarantees no wrap.
// STRUCTURE
//  - Shared package: FP16 width/bias constants (16, 15), scan state encoding (IDLE, SETUP, SCAN),
//    coord width 16.
//  - Sub-module int_to_fp16 (combinational, 16-bit unsigned -> FP16). Instanced for p_x, p_y and
//    the six vertex outputs.
//  - FSM, bbox registers and x/y counters live in this module.
// TESTING
//  1. v=(2,1),(4,1),(3,3), ds_rfd=1 -> 9 pixels (2,1)..(4,3) raster order, one/cycle;
//     first nd at T+2; p_x(2)=0x4000, p_x(3)=0x4200; last only on (4,3).
//  2. Same triangle, ds_rfd toggling 1,0,0,1 -> outputs frozen while nd&!ds_rfd; no pixel skipped or repeated.
//  3. All vertices (5,5) -> exactly one pixel, p_x=p_y=0x4500, last=1; tri_rfd=1 next cycle.
//  4. v=(600,10),(700,10),(650,20), SCREEN_W=640 -> x spans 600..639 only;
//     p_x(600)=0x60B0; last at (639,20).
//  5. All x>=640 -> nd never 1; tri_rfd back to 1 at T+2.
//     tri_nd pulsed during SCAN -> ignored.
//  6. rst on 4th pixel of test 1 -> next cycle nd=0, tri_rfd=1, outputs 0;
//     new triangle then scans from its own min corner.

Source files
------------

// File: rtl/triangle_scan_gen_pkg.sv
// Shared definitions for the triangle scan generator slice.
// Contents: FP16 format constants, coordinate width, scan FSM state
// encoding and small min/max helpers used by the bounding-box setup.
package triangle_scan_gen_pkg;

  localparam int FP16_W   = 16;
  localparam int FP16_BIAS = 15;
  localparam int COORD_W  = 16;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [FP16_W-1:0]  fp16_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2
  } scan_state_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/triangle_scan_gen_if.sv
// Bus interfaces for the triangle scan generator.
//  triangle_scan_gen_tri_if : upstream triangle handoff
//    tri_nd (valid), tri_rfd (ready), v1_x..v3_y integer vertex coords.
//    master = triangle source, slave = scan generator.
//  triangle_scan_gen_pix_if : downstream pixel stream
//    nd (valid), ds_rfd (ready), p_x/p_y FP16, pix_x/pix_y integer,
//    last, o_v1_x..o_v3_y FP16 vertices.
//    master = scan generator, slave = barycentric stage.
interface triangle_scan_gen_tri_if;
  import triangle_scan_gen_pkg::*;

  logic   tri_nd;
  logic   tri_rfd;
  coord_t v1_x, v1_y, v2_x, v2_y, v3_x, v3_y;

  modport master (
    output tri_nd, v1_x, v1_y, v2_x, v2_y, v3_x, v3_y,
    input  tri_rfd
  );

  modport slave (
    input  tri_nd, v1_x, v1_y, v2_x, v2_y, v3_x, v3_y,
    output tri_rfd
  );
endinterface

interface triangle_scan_gen_pix_if;
  import triangle_scan_gen_pkg::*;

  logic   nd;
  logic   ds_rfd;
  fp16_t  p_x, p_y;
  coord_t pix_x, pix_y;
  logic   last;
  fp16_t  o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y;

  modport master (
    output nd, p_x, p_y, pix_x, pix_y, last,
           o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y,
    input  ds_rfd
  );

  modport slave (
    input  nd, p_x, p_y, pix_x, pix_y, last,
           o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y,
    output ds_rfd
  );
endinterface

// File: rtl/triangle_scan_gen_int_to_fp16.sv
// int_to_fp16: combinational unsigned 16-bit integer to IEEE FP16.
//  value_in : unsigned integer
//  fp_out   : FP16 encoding; exact for 0..2047, larger values truncate
//             the mantissa (exponent never overflows since msb <= 15).
module int_to_fp16
  import triangle_scan_gen_pkg::*;
(
  input  coord_t value_in,
  output fp16_t  fp_out
);

  logic [3:0]  msb;
  coord_t      aligned;
  logic [4:0]  exp_field;

  // Locate the leading one, then shift it to bit 15 so the bits below it
  // fall straight into the 10-bit mantissa field.
  always_comb begin
    msb = '0;
    for (int i = 0; i < COORD_W; i++) begin
      if (value_in[i]) msb = 4'(i);
    end
    aligned   = value_in << (4'd15 - msb);
    exp_field = 5'(FP16_BIAS) + {1'b0, msb};
    if (value_in == '0) fp_out = '0;
    else                fp_out = {1'b0, exp_field, aligned[14:5]};
  end

endmodule

// File: rtl/triangle_scan_gen.sv
// triangle_scan_gen: accepts one triangle, computes its screen-clamped
// bounding box and walks it in raster order, one candidate pixel per
// transfer.
//  clk, rst  : clock, synchronous active-high reset
//  tri_bus   : triangle input (tri_nd/tri_rfd handshake, six vertex coords)
//  pix_bus   : pixel output (nd/ds_rfd handshake, FP16 + integer pixel,
//              last flag, FP16 copies of the captured vertices)
module triangle_scan_gen
  import triangle_scan_gen_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic                     clk,
  input logic                     rst,
  triangle_scan_gen_tri_if.slave  tri_bus,
  triangle_scan_gen_pix_if.master pix_bus
);

  localparam coord_t MAX_X = coord_t'(SCREEN_W - 1);
  localparam coord_t MAX_Y = coord_t'(SCREEN_H - 1);

  scan_state_t state, next_state;

  coord_t vx [3];
  coord_t vy [3];
  coord_t min_x, max_x, max_y;
  coord_t x, y;

  coord_t setup_min_x, setup_min_y, setup_max_x, setup_max_y;
  logic   bbox_empty;
  logic   at_last;
  logic   accept;
  logic   transfer;

  // Bounding box of the captured vertices; max is clamped to the screen,
  // while a min beyond the screen means nothing is visible at all.
  always_comb begin
    setup_min_x = min3(vx[0], vx[1], vx[2]);
    setup_min_y = min3(vy[0], vy[1], vy[2]);
    setup_max_x = max3(vx[0], vx[1], vx[2]);
    setup_max_y = max3(vy[0], vy[1], vy[2]);
    if (setup_max_x > MAX_X) setup_max_x = MAX_X;
    if (setup_max_y > MAX_Y) setup_max_y = MAX_Y;
    bbox_empty = (setup_min_x > MAX_X) || (setup_min_y > MAX_Y);
  end

  assign at_last = (x == max_x) && (y == max_y);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    transfer   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tri_bus.tri_nd) begin
          accept     = 1'b1;
          next_state = ST_SETUP;
        end
      end
      ST_SETUP: begin
        next_state = bbox_empty ? ST_IDLE : ST_SCAN;
      end
      ST_SCAN: begin
        if (pix_bus.ds_rfd) begin
          transfer = 1'b1;
          if (at_last) next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Vertex capture, bbox load and raster counters. The final pixel stays
  // on the outputs after the scan; counters only move on a real transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
      min_x <= '0;
      max_x <= '0;
      max_y <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      if (accept) begin
        vx[0] <= tri_bus.v1_x;
        vy[0] <= tri_bus.v1_y;
        vx[1] <= tri_bus.v2_x;
        vy[1] <= tri_bus.v2_y;
        vx[2] <= tri_bus.v3_x;
        vy[2] <= tri_bus.v3_y;
      end
      if (state == ST_SETUP && !bbox_empty) begin
        min_x <= setup_min_x;
        max_x <= setup_max_x;
        max_y <= setup_max_y;
        x     <= setup_min_x;
        y     <= setup_min_y;
      end
      if (transfer && !at_last) begin
        if (x < max_x) begin
          x <= x + 16'd1;
        end else begin
          x <= min_x;
          y <= y + 16'd1;
        end
      end
    end
  end

  assign tri_bus.tri_rfd = (state == ST_IDLE);
  assign pix_bus.nd      = (state == ST_SCAN);
  assign pix_bus.last    = (state == ST_SCAN) && at_last;
  assign pix_bus.pix_x   = x;
  assign pix_bus.pix_y   = y;

  int_to_fp16 u_fp_px (.value_in(x), .fp_out(pix_bus.p_x));
  int_to_fp16 u_fp_py (.value_in(y), .fp_out(pix_bus.p_y));

  int_to_fp16 u_fp_v1x (.value_in(vx[0]), .fp_out(pix_bus.o_v1_x));
  int_to_fp16 u_fp_v1y (.value_in(vy[0]), .fp_out(pix_bus.o_v1_y));
  int_to_fp16 u_fp_v2x (.value_in(vx[1]), .fp_out(pix_bus.o_v2_x));
  int_to_fp16 u_fp_v2y (.value_in(vy[1]), .fp_out(pix_bus.o_v2_y));
  int_to_fp16 u_fp_v3x (.value_in(vx[2]), .fp_out(pix_bus.o_v3_x));
  int_to_fp16 u_fp_v3y (.value_in(vy[2]), .fp_out(pix_bus.o_v3_y));

endmodule

// File: tb/tb_triangle_scan_gen.sv
// Self-checking bench for triangle_scan_gen: directed triangles plus
// randomized ones, compared against a list-of-pixels reference model.
module tb_triangle_scan_gen;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  logic clk;
  logic rst;

  triangle_scan_gen_tri_if tri_bus ();
  triangle_scan_gen_pix_if pix_bus ();

  triangle_scan_gen #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tri_bus(tri_bus.slave),
    .pix_bus(pix_bus.master)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Reference FP16: exponent is floor(log2 v), mantissa is the fractional
  // part of v / 2^e scaled to 10 bits and truncated.
  function automatic logic [15:0] refFp16(input int v);
    int e;
    int man;
    if (v == 0) return 16'h0000;
    e = 0;
    while ((1 << (e + 1)) <= v) e++;
    man = ((v - (1 << e)) << 10) >> e;
    return {1'b0, 5'(15 + e), 10'(man)};
  endfunction

  task automatic driveVerts(input int x1, input int y1, input int x2,
                            input int y2, input int x3, input int y3);
    tri_bus.v1_x = 16'(x1); tri_bus.v1_y = 16'(y1);
    tri_bus.v2_x = 16'(x2); tri_bus.v2_y = 16'(y2);
    tri_bus.v3_x = 16'(x3); tri_bus.v3_y = 16'(y3);
  endtask

  // mode: 0 = ds_rfd always 1, 1 = pattern 1,0,0,1, 2 = random.
  // poke: pulse tri_nd with other vertices during the scan.
  // abort_at: assert rst when this many pixels have transferred (-1 = never).
  task automatic applyStimulus(input int x1, input int y1, input int x2,
                               input int y2, input int x3, input int y3,
                               input int mode, input bit poke, input int abort_at);
    int exp_x[$];
    int exp_y[$];
    int mnx, mxx, mny, mxy;
    int total, popped, cyc, waited;
    bit done;
    bit stop;

    mnx = x1; if (x2 < mnx) mnx = x2; if (x3 < mnx) mnx = x3;
    mny = y1; if (y2 < mny) mny = y2; if (y3 < mny) mny = y3;
    mxx = x1; if (x2 > mxx) mxx = x2; if (x3 > mxx) mxx = x3;
    mxy = y1; if (y2 > mxy) mxy = y2; if (y3 > mxy) mxy = y3;
    if (mxx > SCREEN_W - 1) mxx = SCREEN_W - 1;
    if (mxy > SCREEN_H - 1) mxy = SCREEN_H - 1;
    if (mnx <= SCREEN_W - 1 && mny <= SCREEN_H - 1) begin
      for (int yy = mny; yy <= mxy; yy++)
        for (int xx = mnx; xx <= mxx; xx++) begin
          exp_x.push_back(xx);
          exp_y.push_back(yy);
        end
    end
    total = exp_x.size();

    @(negedge clk);
    waited = 0;
    while (!tri_bus.tri_rfd && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("idle_ready", 32'(tri_bus.tri_rfd), 32'd1);

    driveVerts(x1, y1, x2, y2, x3, y3);
    tri_bus.tri_nd = 1'b1;
    pix_bus.ds_rfd = 1'b0;
    @(negedge clk);
    tri_bus.tri_nd = 1'b0;
    checkOutput("setup_rfd", 32'(tri_bus.tri_rfd), 32'd0);
    checkOutput("setup_nd", 32'(pix_bus.nd), 32'd0);

    if (total == 0) begin
      @(negedge clk);
      checkOutput("empty_rfd", 32'(tri_bus.tri_rfd), 32'd1);
      checkOutput("empty_nd", 32'(pix_bus.nd), 32'd0);
      @(negedge clk);
      checkOutput("empty_nd2", 32'(pix_bus.nd), 32'd0);
      return;
    end

    done = 1'b0;
    stop = 1'b0;
    popped = 0;
    cyc = 0;
    while (!done && !stop && cyc < total * 4 + 20) begin
      @(negedge clk);
      cyc++;
      if (!pix_bus.nd) begin
        checkOutput("scan_nd", 32'(pix_bus.nd), 32'd1);
        stop = 1'b1;
      end else begin
        checkOutput("pix_x", 32'(pix_bus.pix_x), 32'(exp_x[0]));
        checkOutput("pix_y", 32'(pix_bus.pix_y), 32'(exp_y[0]));
        checkOutput("p_x", 32'(pix_bus.p_x), 32'(refFp16(exp_x[0])));
        checkOutput("p_y", 32'(pix_bus.p_y), 32'(refFp16(exp_y[0])));
        checkOutput("last", 32'(pix_bus.last), 32'(popped == total - 1));
        checkOutput("o_v1_x", 32'(pix_bus.o_v1_x), 32'(refFp16(x1)));
        checkOutput("o_v1_y", 32'(pix_bus.o_v1_y), 32'(refFp16(y1)));
        checkOutput("o_v2_x", 32'(pix_bus.o_v2_x), 32'(refFp16(x2)));
        checkOutput("o_v2_y", 32'(pix_bus.o_v2_y), 32'(refFp16(y2)));
        checkOutput("o_v3_x", 32'(pix_bus.o_v3_x), 32'(refFp16(x3)));
        checkOutput("o_v3_y", 32'(pix_bus.o_v3_y), 32'(refFp16(y3)));
        checkOutput("tri_rfd_busy", 32'(tri_bus.tri_rfd), 32'd0);

        if (abort_at >= 0 && popped == abort_at) begin
          rst = 1'b1;
          pix_bus.ds_rfd = 1'b1;
          @(negedge clk);
          checkOutput("abort_nd", 32'(pix_bus.nd), 32'd0);
          checkOutput("abort_rfd", 32'(tri_bus.tri_rfd), 32'd1);
          checkOutput("abort_last", 32'(pix_bus.last), 32'd0);
          checkOutput("abort_pix_x", 32'(pix_bus.pix_x), 32'd0);
          checkOutput("abort_pix_y", 32'(pix_bus.pix_y), 32'd0);
          checkOutput("abort_p_x", 32'(pix_bus.p_x), 32'd0);
          checkOutput("abort_o_v1_x", 32'(pix_bus.o_v1_x), 32'd0);
          rst = 1'b0;
          pix_bus.ds_rfd = 1'b0;
          return;
        end

        case (mode)
          0:       pix_bus.ds_rfd = 1'b1;
          1:       pix_bus.ds_rfd = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
          default: pix_bus.ds_rfd = ($urandom_range(0, 3) != 0);
        endcase

        if (poke && cyc == 3) begin
          driveVerts(100, 200, 110, 210, 120, 220);
          tri_bus.tri_nd = 1'b1;
        end else begin
          driveVerts(x1, y1, x2, y2, x3, y3);
          tri_bus.tri_nd = 1'b0;
        end

        if (pix_bus.ds_rfd) begin
          void'(exp_x.pop_front());
          void'(exp_y.pop_front());
          popped++;
          if (popped == total) done = 1'b1;
        end
      end
    end
    tri_bus.tri_nd = 1'b0;

    if (!done && !stop) checkOutput("scan_timeout", 32'(popped), 32'(total));
    if (done) begin
      @(negedge clk);
      pix_bus.ds_rfd = 1'b0;
      checkOutput("end_nd", 32'(pix_bus.nd), 32'd0);
      checkOutput("end_rfd", 32'(tri_bus.tri_rfd), 32'd1);
      checkOutput("end_last", 32'(pix_bus.last), 32'd0);
    end
  endtask

  initial begin
    int bx, by;
    rst = 1'b1;
    tri_bus.tri_nd = 1'b0;
    pix_bus.ds_rfd = 1'b0;
    driveVerts(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rfd", 32'(tri_bus.tri_rfd), 32'd1);
    checkOutput("rst_nd", 32'(pix_bus.nd), 32'd0);
    checkOutput("rst_last", 32'(pix_bus.last), 32'd0);
    checkOutput("rst_pix_x", 32'(pix_bus.pix_x), 32'd0);
    checkOutput("rst_p_y", 32'(pix_bus.p_y), 32'd0);
    checkOutput("rst_o_v3_y", 32'(pix_bus.o_v3_y), 32'd0);
    rst = 1'b0;

    $display("[TB] basic 3x3 bbox, full throughput");
    applyStimulus(2, 1, 4, 1, 3, 3, 0, 1'b0, -1);
    $display("[TB] same triangle, ds_rfd 1,0,0,1");
    applyStimulus(2, 1, 4, 1, 3, 3, 1, 1'b0, -1);
    $display("[TB] single pixel");
    applyStimulus(5, 5, 5, 5, 5, 5, 0, 1'b0, -1);
    $display("[TB] right-edge clamp");
    applyStimulus(600, 10, 700, 10, 650, 20, 0, 1'b0, -1);
    $display("[TB] fully off-screen");
    applyStimulus(650, 0, 700, 5, 660, 9, 0, 1'b0, -1);
    $display("[TB] tri_nd during scan");
    applyStimulus(2, 1, 4, 1, 3, 3, 0, 1'b1, -1);
    $display("[TB] reset on fourth pixel");
    applyStimulus(2, 1, 4, 1, 3, 3, 0, 1'b0, 3);
    applyStimulus(10, 20, 12, 22, 11, 25, 2, 1'b0, -1);
    $display("[TB] bottom-edge clamp");
    applyStimulus(100, 476, 103, 490, 101, 478, 2, 1'b0, -1);

    $display("[TB] random triangles");
    for (int t = 0; t < 16; t++) begin
      bx = $urandom_range(0, 700);
      by = $urandom_range(0, 500);
      applyStimulus(bx + $urandom_range(0, 6), by + $urandom_range(0, 6),
                    bx + $urandom_range(0, 6), by + $urandom_range(0, 6),
                    bx + $urandom_range(0, 6), by + $urandom_range(0, 6),
                    2, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
